uart_tx_arbiter: RTL

//  Shares the single byte-serial UART transmitter (uart_en/uart_din/uart_tx_busy

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the message sources, the arbiter and the byte-serial UART transmitter.
// Latency: none (wires only).
// Backpressure: sources hold req/req_data until req_ack; the arbiter waits on uart_tx_busy.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   req_ack;
  logic              uart_en;
  logic [7:0]        uart_din;
  logic              uart_tx_busy;
  logic              arb_busy;
  logic              err_timeout;

  // Arbiter side: consumes requests and transmitter status, drives grants and the byte.
  modport master (
    input  req, req_data, req_last, uart_tx_busy,
    output gnt, req_ack, uart_en, uart_din, arb_busy, err_timeout
  );

  // Source / transmitter side.
  modport slave (
    output req, req_data, req_last, uart_tx_busy,
    input  gnt, req_ack, uart_en, uart_din, arb_busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin whole-message arbiter sharing one byte-serial UART transmitter among NREQ sources.
// Latency: req seen in IDLE -> gnt next edge -> uart_en/req_ack one edge later; all outputs registered.
// Backpressure: one byte in flight; next byte only after uart_tx_busy rises and falls (or busy timeout).
module uart_tx_arbiter #(
  parameter int NREQ          = 3,
  parameter int MAX_MSG_BYTES = 16,
  parameter int BUSY_TIMEOUT  = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_MSG_BYTES + 1);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [IW:0]   NREQ_W   = (IW + 1)'(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_MSG_BYTES);
  localparam logic [TW-1:0] TMR_MAX  = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q,       state_d;
  logic [NREQ-1:0] gnt_q,         gnt_d;
  logic [IW-1:0]   gidx_q,        gidx_d;
  logic [IW-1:0]   rr_ptr_q,      rr_ptr_d;
  logic [CW-1:0]   byte_cnt_q,    byte_cnt_d;
  logic [TW-1:0]   timer_q,       timer_d;
  logic            last_q,        last_d;
  logic [7:0]      uart_din_q,    uart_din_d;
  logic            uart_en_q,     uart_en_d;
  logic [NREQ-1:0] req_ack_q,     req_ack_d;
  logic            err_timeout_q, err_timeout_d;
  logic            arb_busy_q,    arb_busy_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     cand_sum;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   next_ptr;
  logic            byte_done;

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IW + 1)'(k);
      if (cand_sum >= NREQ_W) begin
        cand_sum = cand_sum - NREQ_W;
      end
      cand = cand_sum[IW-1:0];
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Pointer value used on message release: one past the requester just served.
  always_comb begin
    next_ptr = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
  end

  // FSM next state and registered-output next values.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    timer_d       = timer_q;
    last_d        = last_q;
    uart_din_d    = uart_din_q;
    uart_en_d     = 1'b0;
    req_ack_d     = '0;
    err_timeout_d = 1'b0;
    byte_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gidx_d          = pick_idx;
          byte_cnt_d      = '0;
          state_d         = LOAD;
        end
      end

      LOAD: begin
        if (bus.req[gidx_q]) begin
          uart_din_d        = bus.req_data[{gidx_q, 3'b000} +: 8];
          uart_en_d         = 1'b1;
          req_ack_d[gidx_q] = 1'b1;
          last_d            = bus.req_last[gidx_q];
          byte_cnt_d        = byte_cnt_q + CW'(1);
          timer_d           = '0;
          state_d           = WAIT_BUSY;
        end else begin
          // Source withdrew mid-message: give the slot up and move the pointer on.
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end

      WAIT_BUSY: begin
        if (bus.uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_MAX) begin
          // Transmitter never acknowledged: flag it and carry on as if the byte went out.
          err_timeout_d = 1'b1;
          byte_done     = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      WAIT_DONE: begin
        if (!bus.uart_tx_busy) begin
          byte_done = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // End of a byte: release on message end or byte cap, otherwise fetch the next byte.
    if (byte_done) begin
      if (last_q || (byte_cnt_q == CNT_MAX)) begin
        gnt_d    = '0;
        rr_ptr_d = next_ptr;
        state_d  = IDLE;
      end else begin
        state_d  = LOAD;
      end
    end

    arb_busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset; reset abandons any message in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      byte_cnt_q    <= '0;
      timer_q       <= '0;
      last_q        <= 1'b0;
      uart_din_q    <= '0;
      uart_en_q     <= 1'b0;
      req_ack_q     <= '0;
      err_timeout_q <= 1'b0;
      arb_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      timer_q       <= timer_d;
      last_q        <= last_d;
      uart_din_q    <= uart_din_d;
      uart_en_q     <= uart_en_d;
      req_ack_q     <= req_ack_d;
      err_timeout_q <= err_timeout_d;
      arb_busy_q    <= arb_busy_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.req_ack     = req_ack_q;
  assign bus.uart_en     = uart_en_q;
  assign bus.uart_din    = uart_din_q;
  assign bus.arb_busy    = arb_busy_q;
  assign bus.err_timeout = err_timeout_q;

endmodule
